// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one sync FIFO write port among N_REQ
// producers, holding each grant for a whole packet (capped at MAX_BURST words)
// and using the FIFO's registered full flag as backpressure.
module sync_fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        fifo_write_o,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data_o,
  input  logic                        fifo_full_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand_idx;
  logic              win_found;
  logic              xfer;
  logic              last_hit;
  logic              cap_hit;

  // State register: reset leaves requester 0 with top priority on the next search.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Convert the one-hot grant into an index so it can become the new rr pointer.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) gnt_idx = PW'(i);
    end
  end

  // Round-robin search: first valid requester after the pointer, wrapping around.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand_idx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_idx = PW'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // A transfer completes when the granted requester is valid and the FIFO has room.
  always_comb begin
    xfer     = (|(grant_q & req_valid_i)) & !fifo_full_i;
    last_hit = |(grant_q & req_last_i);
    cap_hit  = (int'(count_q) + 1 == MAX_BURST);
  end

  // Next-state logic: grant in IDLE, count transfers in LOCKED, release on last or cap.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          count_d          = '0;
          state_d          = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (last_hit || cap_hit) begin
            grant_d = '0;
            ptr_d   = gnt_idx;
            count_d = '0;
            state_d = IDLE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        grant_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: the registered grant steers ready, write strobe and the data mux.
  always_comb begin
    grant_o        = grant_q;
    busy_o         = (state_q == LOCKED);
    req_ready_o    = grant_q & {N_REQ{!fifo_full_i}};
    fifo_write_o   = xfer;
    fifo_wr_data_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) fifo_wr_data_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Testbench for sync_fifo_wr_arbiter: producer queues drive the requesters,
// expected FIFO writes go into a scoreboard popped by an independent monitor.
module tb_sync_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_write;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_full;
  logic [N-1:0]    grant;
  logic            busy;

  logic [DW:0]     prod_q [N][$];
  exp_t            exp_q[$];
  logic [N-1:0]    acc_s;
  logic [N-1:0]    gap_mask;
  logic [DW:0]     head;

  int checks;
  int errors;

  sync_fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .fifo_write_o   (fifo_write),
    .fifo_wr_data_o (fifo_wr_data),
    .fifo_full_i    (fifo_full),
    .grant_o        (grant),
    .busy_o         (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never settles.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] mkWord(input int k, input int tag, input int idx);
    return DW'((k << 28) | (tag << 8) | idx);
  endfunction

  // Handshake is decided by signals that are stable mid-cycle.
  always @(negedge clk) begin
    acc_s = rst_n ? (req_valid & req_ready) : '0;
  end

  // Producers: retire accepted words and present the next queued word.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc_s[k] && prod_q[k].size() > 0) void'(prod_q[k].pop_front());
      if (prod_q[k].size() > 0 && !gap_mask[k]) begin
        head                 = prod_q[k][0];
        req_valid[k]         = 1'b1;
        req_data[k*DW +: DW] = head[DW-1:0];
        req_last[k]          = head[DW];
      end else begin
        req_valid[k]         = 1'b0;
        req_data[k*DW +: DW] = '0;
        req_last[k]          = 1'b0;
      end
    end
  end

  // Monitor: every FIFO write must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (fifo_full) begin
        checks++;
        if (fifo_write) begin
          errors++;
          $display("[TB] FAIL write_while_full: fifo_write=%0b required 0", fifo_write);
        end
      end
      if (fifo_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: data=%h grant=%b, scoreboard empty", fifo_wr_data, grant);
        end else begin
          e = exp_q.pop_front();
          if (fifo_wr_data !== e.data || grant !== e.grant) begin
            errors++;
            $display("[TB] FAIL write_data: got data=%h grant=%b required data=%h grant=%b",
                     fifo_wr_data, grant, e.data, e.grant);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Queue words on requester k; last flag only on the final word when asked.
  task automatic applyStimulus(input int k, input int tag, input int first, input int last_idx,
                               input bit with_last);
    for (int i = first; i <= last_idx; i++) begin
      prod_q[k].push_back({(with_last && i == last_idx), mkWord(k, tag, i)});
    end
  endtask

  // Hand-ordered expectations for the FIFO write stream.
  task automatic expectWords(input int k, input int tag, input int first, input int last_idx);
    exp_t e;
    for (int i = first; i <= last_idx; i++) begin
      e.grant = N'(1 << k);
      e.data  = mkWord(k, tag, i);
      exp_q.push_back(e);
    end
  endtask

  task automatic waitForWrite(input logic [DW-1:0] word);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (fifo_write && fifo_wr_data == word) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL wait_write: word %h never written within 200 cycles", word);
    end
  endtask

  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (prod_q[0].size() == 0 && prod_q[1].size() == 0 && prod_q[2].size() == 0 &&
          prod_q[3].size() == 0 && !busy && exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_timeout: still busy, %0d expected writes outstanding", name, exp_q.size());
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first_c;
    int last_c;
    int nwr;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    acc_s     = '0;
    gap_mask  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_ready", 32'(req_ready), 0);
    checkOutput("reset_write", 32'(fifo_write), 0);
    rst_n = 1'b1;

    // Test 1: req2 three-word packet, one-cycle grant latency
    applyStimulus(2, 1, 1, 3, 1'b1);
    expectWords(2, 1, 1, 3);
    @(negedge clk);
    checkOutput("t1_idle_grant", 32'(grant), 0);
    @(negedge clk);
    checkOutput("t1_grant", 32'(grant), 32'h4);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_ready", 32'(req_ready), 32'h4);
    checkOutput("t1_write", 32'(fifo_write), 1);
    repeat (3) @(negedge clk);
    checkOutput("t1_release_grant", 32'(grant), 0);
    checkOutput("t1_release_busy", 32'(busy), 0);
    waitIdle("t1");

    // Test 2: all four requesters, single-word packets, fair rotation
    pulseReset();
    for (int k = 0; k < N; k++) begin
      applyStimulus(k, 2, 1, 1, 1'b1);
      applyStimulus(k, 2, 2, 2, 1'b1);
    end
    for (int k = 0; k < N; k++) expectWords(k, 2, 1, 1);
    for (int k = 0; k < N; k++) expectWords(k, 2, 2, 2);
    first_c = -1;
    last_c  = -1;
    nwr     = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_write) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        nwr++;
      end
    end
    checkOutput("t2_write_count", 32'(nwr), 8);
    checkOutput("t2_write_span", 32'(last_c - first_c), 14);
    waitIdle("t2");

    // Test 3: burst cap splits a long stream, req3 slips in between
    applyStimulus(1, 3, 1, 20, 1'b1);
    applyStimulus(3, 3, 1, 2, 1'b1);
    expectWords(1, 3, 1, 8);
    expectWords(3, 3, 1, 2);
    expectWords(1, 3, 9, 20);
    waitIdle("t3");

    // Test 4: FIFO full for three cycles after word 2 of 5
    applyStimulus(0, 4, 1, 5, 1'b1);
    expectWords(0, 4, 1, 5);
    waitForWrite(mkWord(0, 4, 2));
    @(posedge clk);
    #2 fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("t4_full_write", 32'(fifo_write), 0);
      checkOutput("t4_full_ready", 32'(req_ready), 0);
      checkOutput("t4_full_grant", 32'(grant), 32'h1);
    end
    @(posedge clk);
    #2 fifo_full = 1'b0;
    waitIdle("t4");

    // Test 5: reset mid-burst on req2, then requester 0 wins
    applyStimulus(2, 5, 1, 6, 1'b1);
    expectWords(2, 5, 1, 2);
    waitForWrite(mkWord(2, 5, 2));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    applyStimulus(0, 5, 1, 1, 1'b1);
    applyStimulus(1, 5, 1, 1, 1'b1);
    applyStimulus(3, 5, 1, 1, 1'b1);
    expectWords(0, 5, 1, 1);
    expectWords(1, 5, 1, 1);
    expectWords(3, 5, 1, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    prod_q[2].delete();
    @(negedge clk);
    checkOutput("t5_reset_grant", 32'(grant), 0);
    checkOutput("t5_reset_busy", 32'(busy), 0);
    @(negedge clk);
    checkOutput("t5_after_reset_grant", 32'(grant), 32'h1);
    waitIdle("t5");

    // Test 6: valid gap mid-packet holds the grant
    applyStimulus(0, 6, 1, 4, 1'b1);
    applyStimulus(1, 6, 1, 1, 1'b1);
    expectWords(0, 6, 1, 4);
    expectWords(1, 6, 1, 1);
    waitForWrite(mkWord(0, 6, 2));
    gap_mask[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("t6_gap_grant", 32'(grant), 32'h1);
      checkOutput("t6_gap_write", 32'(fifo_write), 0);
    end
    gap_mask[0] = 1'b0;
    waitIdle("t6");

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
